dmem_responder: RTL and testbench

- Sequential data-memory responder: the target side of the pipeline's memory-stage access interface (mem_addr, mem_data, mem_read, mem_write, returning valM and dmem_error).
- Replaces the single-cycle combinational data memory with a handshaked, multi-cycle model.
- Word-organized storage; byte addressing; little-endian 64-bit quadwords.
- Configurable latency, two-beat unaligned accesses, and range/illegal-request error reporting suitable for driving the SADR status.

---
 rtl/dmem_responder_pkg.sv | 23 ++
 rtl/dmem_responder_if.sv | 22 ++
 rtl/dmem_responder_lane_shift.sv | 32 +++
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared status codes, state encoding and lane helpers for dmem_responder
package dmem_responder_pkg;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        BEAT_LO,
        BEAT_HI,
        RESP
    } dmem_state_t;

    localparam logic [7:0] LANE_ALL  = 8'hFF;
    localparam logic [7:0] LANE_NONE = 8'h00;

    // Byte-lane count to bit-shift amount (lanes * 8).
    function automatic logic [6:0] lane_bits(input logic [3:0] lanes);
        return {lanes, 3'b000};
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response handshake bundle between pipeline and data memory
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_read, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_read, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/dmem_responder_lane_shift.sv
// rtl/dmem_responder_lane_shift.sv - byte-lane rotation of enables and data for the LO/HI beats
module dmem_lane_shift
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  off,
    input  logic [63:0] wdata,
    input  logic [63:0] lo_word,
    input  logic [63:0] hi_word,
    output logic [7:0]  lo_be,
    output logic [7:0]  hi_be,
    output logic [63:0] lo_wdata,
    output logic [63:0] hi_wdata,
    output logic [63:0] lo_rdata,
    output logic [63:0] hi_rdata
);
    logic [3:0] rem;
    logic [6:0] sh_lo;
    logic [6:0] sh_hi;

    // With off==0 the HI shift is 64 bits, which empties the HI beat entirely.
    assign rem   = 4'd8 - {1'b0, off};
    assign sh_lo = lane_bits({1'b0, off});
    assign sh_hi = lane_bits(rem);

    assign lo_be    = LANE_ALL << off;
    assign hi_be    = (off == 3'd0) ? LANE_NONE : ~lo_be;
    assign lo_wdata = wdata << sh_lo;
    assign hi_wdata = wdata >> sh_hi;
    assign lo_rdata = lo_word >> sh_lo;
    assign hi_rdata = hi_word << sh_hi;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked multi-cycle data memory with unaligned two-beat access and error reporting
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int WORDS   = 128,
    parameter int LATENCY = 1
) (
    input  logic clock,
    input  logic reset_n,
    dmem_responder_if.slave bus
);
    localparam int          IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [63:0] MAX_ADDR = 64'(WORDS * 8 - 8);
    localparam logic [3:0]  LAT      = 4'(LATENCY);

    dmem_state_t   state, state_nx;
    logic [3:0]    wait_cnt;
    logic [IW-1:0] lo_idx;
    logic [2:0]    off;
    logic [63:0]   wdata, rd_buf, resp_rdata, rdata_nx;
    logic          rd, wr, err, resp_error;
    logic          accept, req_err;
    logic [2:0]    status_nx;
    logic [63:0]   mem [WORDS];
    logic [63:0]   lo_word, hi_word, lo_wdata, hi_wdata, lo_rdata, hi_rdata;
    logic [7:0]    lo_be, hi_be;

    // Full-width compare so addresses near 2^64 can never wrap into range.
    assign accept  = bus.req_valid && (state == IDLE);
    assign req_err = (bus.req_addr > MAX_ADDR) || (bus.req_read && bus.req_write);

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = resp_rdata;
    assign bus.resp_error = resp_error;

    assign lo_word = mem[lo_idx];
    assign hi_word = mem[lo_idx + IW'(1)];

    dmem_lane_shift u_lane (
        .off      (off),
        .wdata    (wdata),
        .lo_word  (lo_word),
        .hi_word  (hi_word),
        .lo_be    (lo_be),
        .hi_be    (hi_be),
        .lo_wdata (lo_wdata),
        .hi_wdata (hi_wdata),
        .lo_rdata (lo_rdata),
        .hi_rdata (hi_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Error requests spend one extra WAIT cycle in place of BEAT_LO to keep response timing uniform.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (req_err || LAT != 4'd0) ? WAIT : BEAT_LO;
            WAIT:    if (wait_cnt == 4'd0) state_nx = err ? RESP : BEAT_LO;
            BEAT_LO: state_nx = (off != 3'd0) ? BEAT_HI : RESP;
            BEAT_HI: state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        status_nx = err ? SADR : SAOK;
        rdata_nx  = '0;
        if (!err && rd) begin
            rdata_nx = (state == BEAT_HI) ? (rd_buf | hi_rdata) : lo_rdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt   <= '0;
            lo_idx     <= '0;
            off        <= '0;
            wdata      <= '0;
            rd         <= 1'b0;
            wr         <= 1'b0;
            err        <= 1'b0;
            rd_buf     <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            if (accept) begin
                lo_idx   <= bus.req_addr[IW+2:3];
                off      <= bus.req_addr[2:0];
                wdata    <= bus.req_wdata;
                rd       <= bus.req_read;
                wr       <= bus.req_write;
                err      <= req_err;
                wait_cnt <= req_err ? LAT : LAT - 4'd1;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == BEAT_LO) begin
                rd_buf <= lo_rdata;
            end
            if (state_nx == RESP) begin
                resp_rdata <= rdata_nx;
                resp_error <= (status_nx == SADR);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < 8; b++) begin
            if (state == BEAT_LO && wr && !err && lo_be[b]) begin
                mem[lo_idx][8*b +: 8] <= lo_wdata[8*b +: 8];
            end
            if (state == BEAT_HI && wr && !err && hi_be[b]) begin
                mem[lo_idx + IW'(1)][8*b +: 8] <= hi_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder with WORDS=128, LATENCY=2
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec   = 0;
    int   n_bad   = 0;
    exp_t sb[$];
    logic [7:0] model [1024];

    always #5 clock = ~clock;

    dmem_responder_if bus ();

    dmem_responder #(.WORDS(128), .LATENCY(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    function automatic req_t mk(logic rd, logic wr, logic [63:0] addr, logic [63:0] wdata);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    // Byte-level memory model produces the expectation, then the request is driven and its response captured.
    task automatic run_req(input req_t r, output int lat, output logic [63:0] rdata, output logic err);
        exp_t e;
        int   base;
        e.err   = (r.addr > 64'h3F8) || (r.rd && r.wr);
        e.lat   = (e.err || r.addr[2:0] == 3'd0) ? 4 : 5;
        e.rdata = '0;
        base    = int'(r.addr[9:0]);
        if (!e.err) begin
            for (int i = 0; i < 8; i++) begin
                if (r.wr) model[base+i] = r.wdata[8*i +: 8];
                else if (r.rd) e.rdata[8*i +: 8] = model[base+i];
            end
        end
        sb.push_back(e);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_read  = r.rd;
        bus.req_write = r.wr;
        bus.req_addr  = r.addr;
        bus.req_wdata = r.wdata;
        for (int n = 0; n < 20 && !bus.req_ready; n++) @(negedge clock);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        bus.req_read  = 1'($urandom);
        bus.req_write = 1'($urandom);
        bus.req_addr  = {$urandom, $urandom};
        bus.req_wdata = {$urandom, $urandom};
        lat   = -1;
        rdata = '0;
        err   = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (bus.resp_valid) begin
                lat = k; rdata = bus.resp_rdata; err = bus.resp_error;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat; logic [63:0] rdata; logic err; exp_t e;
        bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_write = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        n_vec += 4;
        if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset ready: got %b want 1", bus.req_ready); end
        if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset resp_valid: got %b want 0", bus.resp_valid); end
        if (bus.resp_rdata !== 64'h0) begin n_bad++; $display("FAIL reset rdata: got %h want 0", bus.resp_rdata); end
        if (bus.resp_error !== 1'b0) begin n_bad++; $display("FAIL reset error: got %b want 0", bus.resp_error); end
        run_req(mk(1'b0, 1'b1, 64'h38, 64'hCAFE_F00D_1234_5678), lat, rdata, err);
        e = sb.pop_front();
        run_req(mk(1'b1, 1'b0, 64'h38, 64'h0), lat, rdata, err);
        e = sb.pop_front();
        n_vec += 1;
        if (rdata !== 64'hCAFE_F00D_1234_5678) begin n_bad++; $display("FAIL reset preload read: got %h want cafef00d12345678", rdata); end
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_read = 1'b1; bus.req_write = 1'b0; bus.req_addr = 64'h38;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        n_vec += 4;
        if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL async reset ready: got %b want 1", bus.req_ready); end
        if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL async reset resp_valid: got %b want 0", bus.resp_valid); end
        if (bus.resp_rdata !== 64'h0) begin n_bad++; $display("FAIL async reset rdata: got %h want 0", bus.resp_rdata); end
        if (bus.resp_error !== 1'b0) begin n_bad++; $display("FAIL async reset error: got %b want 0", bus.resp_error); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_aligned();
        req_t q[$]; int lat; logic [63:0] rdata; logic err; exp_t e;
        q.push_back(mk(1'b0, 1'b1, 64'h40, 64'h1122334455667788));
        q.push_back(mk(1'b1, 1'b0, 64'h40, 64'h0));
        q.push_back(mk(1'b0, 1'b0, 64'h48, 64'h0));
        foreach (q[i]) begin
            run_req(q[i], lat, rdata, err);
            e = sb.pop_front();
            n_vec += 3;
            if (lat !== e.lat) begin n_bad++; $display("FAIL aligned[%0d] latency: got %0d want %0d", i, lat, e.lat); end
            if (rdata !== e.rdata) begin n_bad++; $display("FAIL aligned[%0d] rdata: got %h want %h", i, rdata, e.rdata); end
            if (err !== e.err) begin n_bad++; $display("FAIL aligned[%0d] error: got %b want %b", i, err, e.err); end
            if (i == 1) begin
                n_vec += 1;
                if (rdata !== 64'h1122334455667788) begin n_bad++; $display("FAIL aligned read const: got %h want 1122334455667788", rdata); end
                @(negedge clock);
                n_vec += 2;
                if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL pulse width: got %b want 0", bus.resp_valid); end
                if (bus.resp_rdata !== 64'h1122334455667788) begin n_bad++; $display("FAIL rdata hold: got %h want 1122334455667788", bus.resp_rdata); end
            end
        end
    endtask

    task automatic test_unaligned();
        req_t q[$]; int lat; logic [63:0] rdata; logic err; exp_t e;
        q.push_back(mk(1'b0, 1'b1, 64'h43, 64'hAABBCCDDEEFF0011));
        q.push_back(mk(1'b1, 1'b0, 64'h40, 64'h0));
        q.push_back(mk(1'b1, 1'b0, 64'h43, 64'h0));
        for (int off = 1; off < 8; off++) begin
            q.push_back(mk(1'b0, 1'b1, 64'h100, {$urandom, $urandom}));
            q.push_back(mk(1'b0, 1'b1, 64'h108, {$urandom, $urandom}));
            q.push_back(mk(1'b0, 1'b1, 64'h100 + 64'(off), {$urandom, $urandom}));
            q.push_back(mk(1'b1, 1'b0, 64'h100, 64'h0));
            q.push_back(mk(1'b1, 1'b0, 64'h108, 64'h0));
            q.push_back(mk(1'b1, 1'b0, 64'h100 + 64'(8 - off), 64'h0));
        end
        foreach (q[i]) begin
            run_req(q[i], lat, rdata, err);
            e = sb.pop_front();
            n_vec += 3;
            if (lat !== e.lat) begin n_bad++; $display("FAIL unaligned[%0d] latency: got %0d want %0d", i, lat, e.lat); end
            if (rdata !== e.rdata) begin n_bad++; $display("FAIL unaligned[%0d] rdata: got %h want %h", i, rdata, e.rdata); end
            if (err !== e.err) begin n_bad++; $display("FAIL unaligned[%0d] error: got %b want %b", i, err, e.err); end
            if (i == 1 || i == 2) begin
                n_vec += 1;
                if (i == 1 && rdata !== 64'hDDEEFF0011667788) begin n_bad++; $display("FAIL unaligned merge const: got %h want ddeeff0011667788", rdata); end
                if (i == 2 && rdata !== 64'hAABBCCDDEEFF0011) begin n_bad++; $display("FAIL unaligned read const: got %h want aabbccddeeff0011", rdata); end
            end
        end
    endtask

    task automatic test_range_illegal();
        req_t q[$]; int lat; logic [63:0] rdata; logic err; exp_t e;
        q.push_back(mk(1'b0, 1'b1, 64'h3F8, 64'h0123456789ABCDEF));
        q.push_back(mk(1'b0, 1'b1, 64'h3F9, 64'hFFFF_FFFF_FFFF_FFFF));
        q.push_back(mk(1'b1, 1'b0, 64'h3F8, 64'h0));
        q.push_back(mk(1'b1, 1'b0, 64'h3F9, 64'h0));
        q.push_back(mk(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0));
        q.push_back(mk(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h5555_5555_5555_5555));
        q.push_back(mk(1'b1, 1'b1, 64'h40, 64'h9999_9999_9999_9999));
        q.push_back(mk(1'b1, 1'b0, 64'h40, 64'h0));
        q.push_back(mk(1'b1, 1'b0, 64'h0, 64'h0));
        foreach (q[i]) begin
            run_req(q[i], lat, rdata, err);
            e = sb.pop_front();
            n_vec += 3;
            if (lat !== e.lat) begin n_bad++; $display("FAIL range[%0d] latency: got %0d want %0d", i, lat, e.lat); end
            if (rdata !== e.rdata) begin n_bad++; $display("FAIL range[%0d] rdata: got %h want %h", i, rdata, e.rdata); end
            if (err !== e.err) begin n_bad++; $display("FAIL range[%0d] error: got %b want %b", i, err, e.err); end
        end
    endtask

    task automatic test_back_to_back();
        int acc[$]; int rsp[$];
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_read = 1'b1; bus.req_write = 1'b0; bus.req_addr = 64'h40;
        for (int c = 0; c < 12; c++) begin
            if (bus.req_ready && bus.req_valid) acc.push_back(c);
            if (bus.resp_valid) rsp.push_back(c);
            @(negedge clock);
        end
        bus.req_valid = 1'b0;
        for (int n = 0; n < 20 && !bus.req_ready; n++) @(negedge clock);
        n_vec += 2;
        if (acc.size() != 3 || acc[0] != 0 || acc[1] != 5 || acc[2] != 10) begin
            n_bad++; $display("FAIL b2b accept cycles: got %p want 0,5,10", acc);
        end
        if (rsp.size() != 2 || rsp[0] != 4 || rsp[1] != 9) begin
            n_bad++; $display("FAIL b2b response cycles: got %p want 4,9", rsp);
        end
    endtask

    task automatic test_reset_midop();
        int lat; logic [63:0] rdata; logic err; exp_t e; int seen;
        run_req(mk(1'b0, 1'b1, 64'h80, 64'h0F0E_0D0C_0B0A_0908), lat, rdata, err);
        e = sb.pop_front();
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_read = 1'b0; bus.req_write = 1'b1;
        bus.req_addr = 64'h80; bus.req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.resp_valid) seen++;
            @(negedge clock);
        end
        n_vec += 2;
        if (seen != 0) begin n_bad++; $display("FAIL midop response pulses: got %0d want 0", seen); end
        if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL midop ready: got %b want 1", bus.req_ready); end
        run_req(mk(1'b1, 1'b0, 64'h80, 64'h0), lat, rdata, err);
        e = sb.pop_front();
        n_vec += 3;
        if (lat !== e.lat) begin n_bad++; $display("FAIL midop latency: got %0d want %0d", lat, e.lat); end
        if (rdata !== 64'h0F0E_0D0C_0B0A_0908) begin n_bad++; $display("FAIL midop word: got %h want 0f0e0d0c0b0a0908", rdata); end
        if (err !== e.err) begin n_bad++; $display("FAIL midop error: got %b want %b", err, e.err); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_aligned();
        test_unaligned();
        test_range_illegal();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
